// File: rtl/i2s_rx_capture_pkg.sv
//------------------------------------------------------------------------------
// i2s_rx_pkg
// Shared constants and types for the I2S receive capture engine.
//   DATA_W     : sample / SDRAM word width
//   BIT_CNT_W  : width of the per-slot bit counter (delay bit + 16 data bits + saturation)
//   wr_state_t : SDRAM write FSM states
//   channel_t  : slot channel, LRClk low = left
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package i2s_rx_pkg;
  localparam int DATA_W    = 16;
  localparam int BIT_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ADV  = 2'd2
  } wr_state_t;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } channel_t;
endpackage

// File: rtl/i2s_rx_capture_if.sv
//------------------------------------------------------------------------------
// i2s_rx_capture_if
// SDRAM arbiter write-port bundle.
//   sdram_wr   : write request (requester -> arbiter)
//   sdram_addr : word address
//   sdram_data : write data
//   sdram_be   : byte enables
//   sdram_ac   : one-cycle acknowledge (arbiter -> requester)
// Modports: master = requester (capture engine), slave = arbiter.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface i2s_rx_capture_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 25
);
  logic              sdram_wr;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_data;
  logic [1:0]        sdram_be;
  logic              sdram_ac;

  modport master (
    output sdram_wr, sdram_addr, sdram_data, sdram_be,
    input  sdram_ac
  );

  modport slave (
    input  sdram_wr, sdram_addr, sdram_data, sdram_be,
    output sdram_ac
  );
endinterface

// File: rtl/i2s_rx_capture_fifo.sv
//------------------------------------------------------------------------------
// i2s_rx_fifo
// Synchronous sample FIFO (FIFO_DEPTH must be a power of two).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write strobe and data (ignored when full unless popping)
//   i_pop          : read strobe, advances past the head word
//   i_flush        : discard all contents
//   o_data         : head word (valid while !o_empty)
//   o_full, o_empty: occupancy flags
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module i2s_rx_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == DEPTH_C);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/i2s_rx_capture.sv
//------------------------------------------------------------------------------
// i2s_rx_capture
// Deserializes I2S ADC samples and writes them into a circular SDRAM buffer.
//   Clk50    : system clock          reset_n  : async active-low reset
//   LRClk    : codec word clock      SClk     : codec bit clock
//   Din      : codec serial data     enable   : capture enable (level)
//   sdram    : arbiter write port (master modport of i2s_rx_capture_if)
//   busy     : capturing or draining overflow : sticky sample-dropped flag
//   wrap     : one-cycle pulse when the address wraps to BASE_ADDR
// Build option: define I2S_RX_MONO_EN to store left-slot samples only.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module i2s_rx_capture
  import i2s_rx_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 25,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 25'h100000,
  parameter logic [ADDR_W-1:0] BUF_WORDS  = 25'h080000
) (
  input  logic             Clk50,
  input  logic             reset_n,
  input  logic             LRClk,
  input  logic             SClk,
  input  logic             Din,
  input  logic             enable,
  i2s_rx_capture_if.master sdram,
  output logic             busy,
  output logic             overflow,
  output logic             wrap
);
  localparam logic [ADDR_W-1:0]    LAST_ADDR = BASE_ADDR + BUF_WORDS - ADDR_W'(1);
  localparam logic [BIT_CNT_W-1:0] CNT_LAST  = BIT_CNT_W'(DATA_W);
  localparam logic [BIT_CNT_W-1:0] CNT_SAT   = BIT_CNT_W'(DATA_W + 1);

  // [0],[1] synchronize; [2] holds the previous synchronized value for edge detect.
  logic [2:0] r_lr_sync;
  logic [2:0] r_sck_sync;
  logic [1:0] r_din_sync;

  logic                 r_en_d;
  logic                 r_armed;
  logic                 r_slot_valid;
  channel_t             r_chan;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [DATA_W-1:0]    r_shift;
  logic                 r_push;
  logic [DATA_W-1:0]    r_push_data;

  wr_state_t            r_state;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_data;
  logic                 r_busy;
  logic                 r_overflow;

  logic              w_lr_edge;
  logic              w_lr_fall;
  logic              w_sck_rise;
  logic              w_din;
  logic [DATA_W-1:0] w_word;
  logic              w_chan_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_fifo_data;

  assign w_lr_edge  = r_lr_sync[1] ^ r_lr_sync[2];
  assign w_lr_fall  = ~r_lr_sync[1] & r_lr_sync[2];
  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_din      = r_din_sync[1];
  assign w_word     = {r_shift[DATA_W-2:0], w_din};

`ifdef I2S_RX_MONO_EN
  assign w_chan_ok = (r_chan == CH_L);
`else
  assign w_chan_ok = 1'b1;
`endif

  always_ff @(posedge Clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_lr_sync  <= '0;
      r_sck_sync <= '0;
      r_din_sync <= '0;
    end else begin
      r_lr_sync  <= {r_lr_sync[1:0], LRClk};
      r_sck_sync <= {r_sck_sync[1:0], SClk};
      r_din_sync <= {r_din_sync[0], Din};
    end
  end

  // Slot framing. A slot only captures once armed, and arming happens on a
  // left-slot start so buffer word 0 is always a left sample.
  always_ff @(posedge Clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_en_d       <= 1'b0;
      r_armed      <= 1'b0;
      r_slot_valid <= 1'b0;
      r_chan       <= CH_L;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
    end else begin
      r_en_d <= enable;
      r_push <= 1'b0;
      if (!enable) begin
        r_armed      <= 1'b0;
        r_slot_valid <= 1'b0;
      end else if (w_lr_edge) begin
        r_bit_cnt    <= '0;
        r_chan       <= r_lr_sync[1] ? CH_R : CH_L;
        r_slot_valid <= r_armed | w_lr_fall;
        if (w_lr_fall) r_armed <= 1'b1;
      end else if (w_sck_rise && r_slot_valid) begin
        // Count 0 is the I2S delay bit; counts 1..DATA_W carry data, then saturate.
        if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        if (r_bit_cnt != '0 && r_bit_cnt <= CNT_LAST) r_shift <= w_word;
        if (r_bit_cnt == CNT_LAST) begin
          r_push      <= w_chan_ok;
          r_push_data <= w_word;
        end
      end
    end
  end

  assign w_push  = r_push & enable;
  assign w_pop   = (r_state == REQ) & sdram.sdram_ac;
  // Flushing waits for IDLE so an outstanding request always completes its handshake.
  assign w_flush = ~enable & (r_state == IDLE);

  i2s_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (Clk50),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge Clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr     <= BASE_ADDR;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_busy <= enable | (r_state != IDLE) | ~w_empty | r_push;
      if (enable && !r_en_d)               r_overflow <= 1'b0;
      else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (!enable) begin
            r_addr <= BASE_ADDR;
          end else if (!w_empty) begin
            r_data  <= w_fifo_data;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (sdram.sdram_ac) r_state <= ADV;
        end
        ADV: begin
          r_addr  <= (r_addr == LAST_ADDR) ? BASE_ADDR : r_addr + ADDR_W'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sdram.sdram_wr   = (r_state == REQ);
  assign sdram.sdram_addr = r_addr;
  assign sdram.sdram_data = r_data;
  assign sdram.sdram_be   = (r_state == REQ) ? 2'b11 : 2'b00;
  assign busy             = r_busy;
  assign overflow         = r_overflow;
  assign wrap             = (r_state == ADV) && (r_addr == LAST_ADDR);
endmodule

// File: doc/i2s_rx_capture.md
# i2s_rx_capture

I2S receive-side capture engine: deserializes 16-bit stereo samples from the audio codec ADC data line and writes them as 16-bit words into a circular buffer in SDRAM through the SDRAM arbiter's write port. It is the capture counterpart of the playback I2S block, which reads from SDRAM. It shares the codec LRClk/SClk pins, and the arbiter is extended with one more requester.

## Interface
Parameters:
- DATA_W, 16, sample and SDRAM word width
- ADDR_W, 25, SDRAM word-address width
- FIFO_DEPTH, 8, sample FIFO entries (power of two)
- BASE_ADDR, 25'h100000, first word of capture buffer
- BUF_WORDS, 25'h080000, buffer length in words (≥2)

Ports:
- Clk50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- LRClk  in  1  codec word clock (async); low = left
- SClk  in  1  codec bit clock (async, ≤ 4 MHz)
- Din  in  1  codec ADC serial data (async)
- enable  in  1  capture enable, level
- sdram_wr  out  1  write request to arbiter
- sdram_addr  out  ADDR_W  word address
- sdram_data  out  DATA_W  write data
- sdram_be  out  2  byte enables, always 2'b11 while sdram_wr
- sdram_ac  in  1  one-cycle acknowledge from arbiter
- busy  out  1  high while capturing or while draining
- overflow  out  1  sticky: sample dropped on full FIFO
- wrap  out  1  one-cycle pulse when the address wraps to BASE_ADDR

## Operation
- LRClk, SClk, and Din each pass through a 2-FF synchronizer. SClk and LRClk edges are detected from the synchronized values.
- Framing (I2S standard) is evaluated on SClk rising:
  - An LRClk change arms a new slot and resets bit_cnt to 0.
  - The first rising edge of a slot is the I2S delay bit and is ignored.
  - The next 16 rising edges shift Din in MSB-first. Further bits in the slot are ignored.
- After the 16th bit, the word is pushed to the FIFO with the channel order preserved (left, then right).
- Arming: after enable rises, nothing is pushed until the first LRClk falling edge (start of a left slot). This keeps buffer word 0 as a left sample.
- Write FSM states:
  - IDLE: if the FIFO is not empty, go to REQ.
  - REQ: sdram_wr=1. Address and data are held stable until sdram_ac. On sdram_ac, pop the FIFO and go to ADV.
  - ADV: sdram_wr=0. Address increments; if the address equals BASE_ADDR+BUF_WORDS-1 it loads BASE_ADDR instead and wrap pulses. Return to IDLE.
- Overflow: a push to a full FIFO drops the sample and sets overflow. Push and pop in the same cycle on a full FIFO is legal and does not set overflow. overflow clears on enable rising.
- Disable mid-operation: an outstanding REQ is held until sdram_ac (the arbiter handshake is never abandoned). Framing then stops, the FIFO is flushed, the address returns to BASE_ADDR, and busy falls.
- Reset values: sdram_wr=0, sdram_addr=BASE_ADDR, sdram_data=0, sdram_be=0, busy=0, overflow=0, wrap=0. FSM is in IDLE, FIFO is empty, framing is disarmed.

## Timing
- Pin edge to detected edge: 3 Clk50 cycles (2 sync + 1 edge register).
- 16th-bit detection to FIFO push: 1 cycle.
- FIFO non-empty to sdram_wr high: 2 cycles (IDLE→REQ registered).
- sdram_ac to next sdram_wr: ≥2 cycles (ADV, IDLE). The minimum sustained rate is one word per 3 cycles plus arbiter latency.
- At 48 kHz stereo a word arrives every ~520 Clk50 cycles, so FIFO_DEPTH covers ~4000 cycles of arbiter stall.
- wrap is asserted in the ADV cycle only.

## Configuration
- I2S_RX_MONO_EN
  - Defined: only left-slot words are pushed and right slots are ignored. The buffer holds consecutive left samples.
  - Undefined: both channels are stored, interleaved L,R.

## Structure
- Package i2s_rx_pkg holds:
  - DATA_W and BIT_CNT_W constants
  - write-FSM enum typedef {IDLE, REQ, ADV}
  - channel enum typedef {CH_L, CH_R}
- Sub-module i2s_rx_fifo: synchronous FIFO, parameterized DATA_W/FIFO_DEPTH, with push/pop/full/empty/flush.

## Test plan
- Stereo frame L=16'hA5C3, R=16'h1234, arbiter acks after 1 cycle → writes 16'hA5C3 to BASE_ADDR, then 16'h1234 to BASE_ADDR+1, sdram_be=2'b11.
- enable raised mid-right-slot → the partial right slot and the remainder of that frame are discarded. The first write is the next left word at BASE_ADDR.
- BUF_WORDS=4, capture 5 words → addresses BASE..BASE+3 then BASE. wrap pulses once, in the ADV after the write to BASE+3.
- Arbiter holds sdram_ac low for 10 frames with FIFO_DEPTH=8 → overflow=1, the first 8 words are preserved in order and later words are dropped. The next enable rising clears overflow.
- enable dropped while in REQ, sdram_ac 5 cycles later → sdram_wr stays high until ack. The FIFO is then flushed, sdram_addr=BASE_ADDR, and busy=0.
- reset_n pulsed low mid-word → all outputs take their reset values asynchronously. No write is issued until a fresh enable plus LRClk falling edge.
